rc4_prga_decrypt: RTL and testbench
===================================

# rc4_prga_decrypt

Keystream-generation and decryption stage of the RC4 key-search datapath. It is launched by the search controller's `start_compute` level after the S-array init and shuffle stages have run for the current key. It runs the RC4 PRGA over the 256-byte S memory, XORs each keystream byte with the ciphertext ROM, and writes plaintext to the decrypted RAM. It returns `finish_compute` together with `invalid_ascii`, which the controller uses to either advance the key or stop.

## Interface

Parameters:
- MSG_LEN, 32: message length in bytes, range 1..256.
- KW, $clog2(MSG_LEN): width of the message index.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_compute  in  1  level request from the controller; high while the controller is in COMPUTE.
- finish_compute  out  1  one-cycle completion pulse.
- invalid_ascii  out  1  sticky result flag; valid in the `finish_compute` cycle and held until the next start.
- s_address  out  8  S memory address.
- s_data  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- s_q  in  8  S memory read data; 1-cycle read latency.
- e_address  out  KW  ciphertext ROM address.
- e_q  in  8  ciphertext ROM data; 1-cycle read latency.
- d_address  out  KW  plaintext RAM address.
- d_data  out  8  plaintext RAM write data.
- d_wren  out  1  plaintext RAM write enable.

## Operation

- States: IDLE, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, READ_F, WAIT_F, WRITE_D, DONE.
- IDLE:
  - All memory outputs are 0.
  - When `start_compute`=1: clear i, j, k and `invalid_ascii`, then go to READ_I.
- Per byte k, 9 cycles:
  - READ_I: `s_address`=i+1; the i register takes i+1.
  - WAIT_I: capture si←`s_q` at the exit edge.
  - READ_J: `s_address`=j+si; the j register takes that value.
  - WAIT_J: capture sj←`s_q`.
  - WRITE_I: write S[i]=sj.
  - WRITE_J: write S[j]=si.
  - READ_F: `s_address`=si+sj using the captured pre-swap values; `e_address`=k.
  - WAIT_F: capture f←`s_q` and c←`e_q`.
  - WRITE_D: `d_address`=k, `d_data`=f^c, `d_wren`=1.
    - If f^c is not in 0x61..0x7A and is not 0x20, set `invalid_ascii`.
    - If k=MSG_LEN-1, go to DONE; otherwise increment k and go to READ_I.
- All index arithmetic on i, j and si+sj is 8-bit modulo-256 and wraps silently.
- The i==j case needs no special handling: both writes store the same value.
- DONE:
  - `finish_compute`=1 for exactly the first DONE cycle.
  - Stay in DONE while `start_compute`=1; return to IDLE on the first cycle `start_compute`=0.
  - A start level still held high in the finish cycle never triggers a second run.
- `start_compute` is ignored outside IDLE and DONE. Deasserting it mid-run does not abort the run.
- The S port is shared with the init and shuffle stages through an external mux. This block drives `s_wren`=0 and `s_address`=0 whenever it is in IDLE or DONE.

## Timing

- Reset (asynchronous, any state): go to IDLE; i=j=k=0.
  - Reset values: `finish_compute`=0, `invalid_ascii`=0, all addresses 0, all data 0, all write enables 0.
- Reset mid-run aborts immediately. A partially written plaintext RAM is acceptable.
- Latency: the edge sampling `start_compute`=1 in IDLE is cycle 0. `finish_compute` is high in cycle 9·MSG_LEN+1, which is cycle 289 for the default MSG_LEN.
- At most one write enable is active in any cycle.
- `invalid_ascii` does not change between the `finish_compute` cycle and the next start.

## Configuration

- RC4_EARLY_ABORT_EN defined: when WRITE_D detects an invalid byte, go directly to DONE.
  - `invalid_ascii`=1.
  - Finish latency is 9·(k+1)+1 cycles.
  - Plaintext RAM is written only up to and including byte k.
- Undefined: all MSG_LEN bytes are always processed.
  - Latency is fixed at 9·MSG_LEN+1.

## Test plan

- Reset check: assert reset mid-run at byte 10 -> all outputs 0 in the same cycle; the next start runs a full 289-cycle pass.
- Valid decrypt:
  - Setup: identity S (S[n]=n); e[0]=0x63, e[1]=0x64; remaining bytes encode "a" under a golden-model keystream.
  - Required: keystream 0x02, 0x05; d[0]=d[1]=0x61; `finish_compute` pulse in cycle 289; `invalid_ascii`=0; all 32 d-RAM bytes match the model.
- Invalid decrypt: identity S, e[0]=0x02 -> d[0]=0x00; `invalid_ascii`=1 at finish (macro undefined: still 32 `d_wren` pulses).
- Handshake: hold `start_compute` high 5 cycles past finish -> exactly one `finish_compute` pulse and no restart; dropping and then reasserting start launches a new run with `invalid_ascii` cleared.
- Wrap/alias: S loaded so that j+si overflows and i==j occurs at byte 0 -> S contents and plaintext match the golden model; no stray writes.
- RC4_EARLY_ABORT_EN: invalid byte at k=0 -> `finish_compute` in cycle 10; exactly one `d_wren` pulse; `invalid_ascii`=1.

Source files
------------

// File: rtl/rc4_prga_decrypt.sv
// rc4_prga_decrypt: RC4 PRGA over the shared S memory, XOR with the ciphertext ROM, plaintext to RAM.
// Optional feature macro RC4_EARLY_ABORT_EN: finish at the first plaintext byte outside a..z / space.
module rc4_prga_decrypt #(
   parameter int MSG_LEN = 32,
   parameter int KW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_compute,
   output logic          finish_compute,
   output logic          invalid_ascii,
   output logic [7:0]    s_address,
   output logic [7:0]    s_data,
   output logic          s_wren,
   input  logic [7:0]    s_q,
   output logic [KW-1:0] e_address,
   input  logic [7:0]    e_q,
   output logic [KW-1:0] d_address,
   output logic [7:0]    d_data,
   output logic          d_wren
);

   // state   | meaning
   // IDLE    | S port released, wait for start
   // READ_I  | read S[i+1], advance i
   // WAIT_I  | capture si
   // READ_J  | read S[j+si], advance j
   // WAIT_J  | capture sj
   // WRITE_I | S[i] = sj
   // WRITE_J | S[j] = si
   // READ_F  | read S[si+sj] and ciphertext[k]
   // WAIT_F  | capture keystream byte f and ciphertext c
   // WRITE_D | plaintext[k] = f ^ c, check character class
   // DONE    | pulse finish, hold until start drops
   typedef enum logic [3:0] {
      IDLE, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, READ_F, WAIT_F, WRITE_D, DONE
   } state_t;

   state_t        state, state_nxt;
   logic [7:0]    i, j, si, sj, f, c;
   logic [KW-1:0] k;
   logic          done_hold;
   logic [7:0]    pt;
   logic          pt_bad;
   logic          last_byte;

   assign pt        = f ^ c;
   assign pt_bad    = !((pt >= 8'h61 && pt <= 8'h7A) || pt == 8'h20);
   assign last_byte = (k == KW'(MSG_LEN - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_compute) state_nxt = READ_I;
         READ_I:  state_nxt = WAIT_I;
         WAIT_I:  state_nxt = READ_J;
         READ_J:  state_nxt = WAIT_J;
         WAIT_J:  state_nxt = WRITE_I;
         WRITE_I: state_nxt = WRITE_J;
         WRITE_J: state_nxt = READ_F;
         READ_F:  state_nxt = WAIT_F;
         WAIT_F:  state_nxt = WRITE_D;
         WRITE_D: begin
            if (last_byte) state_nxt = DONE;
`ifdef RC4_EARLY_ABORT_EN
            else if (pt_bad) state_nxt = DONE;
`endif
            else state_nxt = READ_I;
         end
         DONE:    if (!start_compute) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_address      = '0;
      s_data         = '0;
      s_wren         = 1'b0;
      e_address      = '0;
      d_address      = '0;
      d_data         = '0;
      d_wren         = 1'b0;
      finish_compute = 1'b0;
      case (state)
         READ_I:  s_address = i + 8'd1;
         READ_J:  s_address = j + si;
         WRITE_I: begin
            s_address = i;
            s_data    = sj;
            s_wren    = 1'b1;
         end
         WRITE_J: begin
            s_address = j;
            s_data    = si;
            s_wren    = 1'b1;
         end
         READ_F: begin
            s_address = si + sj;
            e_address = k;
         end
         WRITE_D: begin
            d_address = k;
            d_data    = pt;
            d_wren    = 1'b1;
         end
         DONE:    finish_compute = !done_hold;
         default: ;
      endcase
   end

   // done_hold limits finish_compute to the first DONE cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         i             <= '0;
         j             <= '0;
         k             <= '0;
         si            <= '0;
         sj            <= '0;
         f             <= '0;
         c             <= '0;
         invalid_ascii <= 1'b0;
         done_hold     <= 1'b0;
      end else begin
         done_hold <= (state == DONE);
         case (state)
            IDLE: begin
               if (start_compute) begin
                  i             <= '0;
                  j             <= '0;
                  k             <= '0;
                  invalid_ascii <= 1'b0;
               end
            end
            READ_I: i <= i + 8'd1;
            WAIT_I: si <= s_q;
            READ_J: j <= j + si;
            WAIT_J: sj <= s_q;
            WAIT_F: begin
               f <= s_q;
               c <= e_q;
            end
            WRITE_D: begin
               if (pt_bad)     invalid_ascii <= 1'b1;
               if (!last_byte) k <= k + KW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: memory models, textbook RC4 reference, scoreboard on plaintext writes.
module tb_rc4_prga_decrypt;
   localparam int MSG_LEN = 32;
   localparam int KW      = $clog2(MSG_LEN);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          finish_compute, invalid_ascii;
   logic [7:0]    s_address, s_data, s_q, e_q, d_data;
   logic          s_wren, d_wren;
   logic [KW-1:0] e_address, d_address;

   always #5 clk = ~clk;

   rc4_prga_decrypt #(.MSG_LEN(MSG_LEN)) dut (
      .clk(clk), .reset(rst), .start_compute(start),
      .finish_compute(finish_compute), .invalid_ascii(invalid_ascii),
      .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
      .e_address(e_address), .e_q(e_q),
      .d_address(d_address), .d_data(d_data), .d_wren(d_wren)
   );

   logic [7:0]  s_mem [256];
   logic [7:0]  s_init[256];
   logic [7:0]  s_ref [256];
   logic [7:0]  e_mem [MSG_LEN];
   logic [7:0]  d_mem [MSG_LEN];
   logic [7:0]  ks    [MSG_LEN];
   logic        load_req = 1'b0;
   logic [15:0] exp_q[$];
   int          n_checks = 0, n_fail = 0, n_wr = 0, n_finish = 0;

   // S memory is loaded from s_init on request so only this block writes it
   always @(posedge clk) begin
      if (load_req) begin
         for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
      end else if (s_wren) begin
         s_mem[s_address] <= s_data;
      end
      s_q <= s_mem[s_address];
      e_q <= e_mem[e_address];
      if (d_wren) d_mem[d_address] <= d_data;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (finish_compute) n_finish++;
         if (s_wren || d_wren) chk("one_wren", {31'd0, s_wren & d_wren}, 32'd0);
         if (d_wren) begin
            n_wr++;
            if (exp_q.size() == 0) chk("stray_d_write", {24'd0, d_data}, 32'hFFFF_FFFF);
            else chk("d_write", {16'd0, 8'(d_address), d_data}, {16'd0, exp_q.pop_front()});
         end
      end
   end

   // Reference RC4 PRGA over a plain array copy of the loaded S
   task automatic gen_ks();
      int ii, jj;
      logic [7:0] t;
      for (int n = 0; n < 256; n++) s_ref[n] = s_init[n];
      ii = 0;
      jj = 0;
      for (int kk = 0; kk < MSG_LEN; kk++) begin
         ii = (ii + 1) % 256;
         jj = (jj + s_ref[ii]) % 256;
         t = s_ref[ii]; s_ref[ii] = s_ref[jj]; s_ref[jj] = t;
         ks[kk] = s_ref[(s_ref[ii] + s_ref[jj]) % 256];
      end
   endtask

   task automatic build_expect(output int n_bytes, output bit bad);
      logic [7:0] p;
      bad = 1'b0;
      n_bytes = 0;
      for (int kk = 0; kk < MSG_LEN; kk++) begin
         p = ks[kk] ^ e_mem[kk];
         exp_q.push_back({8'(kk), p});
         n_bytes++;
         if (!(p == 8'h20 || (p >= 8'h61 && p <= 8'h7A))) bad = 1'b1;
`ifdef RC4_EARLY_ABORT_EN
         if (bad) break;
`endif
      end
   endtask

   task automatic load_s();
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
   endtask

   task automatic identity_s();
      for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
   endtask

   task automatic random_s();
      int r;
      logic [7:0] t;
      identity_s();
      for (int n = 255; n > 0; n--) begin
         r = $urandom_range(n, 0);
         t = s_init[n]; s_init[n] = s_init[r]; s_init[r] = t;
      end
   endtask

   task automatic swap_value_to(input logic [7:0] v, input int pos);
      logic [7:0] t;
      for (int n = 0; n < 256; n++) begin
         if (s_init[n] == v) begin
            t = s_init[pos]; s_init[pos] = s_init[n]; s_init[n] = t;
            break;
         end
      end
   endtask

   function automatic logic [7:0] rand_char();
      if ($urandom_range(5, 0) == 0) return 8'h20;
      return 8'(8'h61 + $urandom_range(25, 0));
   endfunction

   task automatic run(input int hold, output int n_bytes);
      bit bad;
      int cyc, wr0, fin0;
      build_expect(n_bytes, bad);
      wr0  = n_wr;
      fin0 = n_finish;
      @(negedge clk); start = 1'b1;
      cyc = 0;
      while (cyc < 4000) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         if (cyc == 1) chk("invalid_cleared", {31'd0, invalid_ascii}, 32'd0);
         if (finish_compute) break;
      end
      chk("finish_cycle", cyc, 9 * n_bytes + 1);
      chk("invalid_at_finish", {31'd0, invalid_ascii}, {31'd0, bad});
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         chk("held_no_restart", {22'd0, finish_compute, s_wren, s_address}, 32'd0);
      end
      start = 1'b0;
      @(negedge clk);
      chk("idle_s_port", {22'd0, s_wren, s_address, d_wren}, 32'd0);
      chk("finish_pulses", n_finish - fin0, 1);
      chk("d_wren_count", n_wr - wr0, n_bytes);
      chk("queue_empty", exp_q.size(), 0);
      chk("invalid_held", {31'd0, invalid_ascii}, {31'd0, bad});
   endtask

   task automatic check_s_final();
      int diffs = 0;
      for (int n = 0; n < 256; n++) if (s_mem[n] !== s_ref[n]) diffs++;
      chk("s_final", diffs, 0);
   endtask

   task automatic valid_cipher();
      identity_s();
      gen_ks();
      e_mem[0] = 8'h63;
      e_mem[1] = 8'h64;
      for (int kk = 2; kk < MSG_LEN; kk++) e_mem[kk] = ks[kk] ^ 8'h61;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, cyc, wr0;
      rst   = 1'b1;
      start = 1'b0;
      identity_s();
      for (int kk = 0; kk < MSG_LEN; kk++) e_mem[kk] = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_ctrl", {22'd0, finish_compute, invalid_ascii, s_address}, 32'd0);
      chk("reset_data", {7'd0, s_data, s_wren, e_address, d_address, d_data, d_wren}, 32'd0);
      load_s();
      @(negedge clk); rst = 1'b0;

      // Valid decrypt from identity S: every byte should be 'a'
      valid_cipher();
      load_s();
      run(0, nb);
      chk("d0_valid", {24'd0, d_mem[0]}, 32'h61);
      chk("d1_valid", {24'd0, d_mem[1]}, 32'h61);
      for (int kk = 0; kk < MSG_LEN; kk++) chk("d_all_a", {24'd0, d_mem[kk]}, 32'h61);
      check_s_final();

      // Invalid first byte, start held past finish
      valid_cipher();
      e_mem[0] = 8'h02;
      load_s();
      run(5, nb);
      chk("d0_invalid", {24'd0, d_mem[0]}, 32'h00);

      // Restart after the invalid run clears the flag
      valid_cipher();
      load_s();
      run(0, nb);

      // Alias at byte 0 (S[1]=1 gives i==j) and j overflow at byte 1 (S[2]=0xFF)
      random_s();
      swap_value_to(8'h01, 1);
      swap_value_to(8'hFF, 2);
      gen_ks();
      for (int kk = 0; kk < MSG_LEN; kk++) e_mem[kk] = ks[kk] ^ rand_char();
      load_s();
      run(0, nb);
      check_s_final();

      // Random permutations with occasional invalid bytes
      for (int r = 0; r < 3; r++) begin
         random_s();
         gen_ks();
         for (int kk = 0; kk < MSG_LEN; kk++)
            e_mem[kk] = ($urandom_range(15, 0) == 0) ? 8'($urandom) : (ks[kk] ^ rand_char());
         load_s();
         run(0, nb);
         if (nb == MSG_LEN) check_s_final();
      end

      // Reset in the middle of byte 10, then a full pass
      valid_cipher();
      load_s();
      build_expect(nb, cyc[0]);
      wr0 = n_wr;
      @(negedge clk); start = 1'b1;
      cyc = 0;
      while ((n_wr - wr0) < 10 && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      chk("reached_byte10", n_wr - wr0, 10);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrun_reset_ctrl", {22'd0, finish_compute, invalid_ascii, s_address}, 32'd0);
      chk("midrun_reset_data", {7'd0, s_data, s_wren, e_address, d_address, d_data, d_wren}, 32'd0);
      exp_q.delete();
      start = 1'b0;
      @(negedge clk); rst = 1'b0;
      valid_cipher();
      load_s();
      run(0, nb);
      chk("post_reset_bytes", nb, MSG_LEN);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
